// File: rtl/digit_serial_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
// Slice count, counter width and the geometry check live here.
package digit_serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int num_slices(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int cnt_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit width_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && (width % digit == 0);
    endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit slice: ripple of full-subtractor bit cells.
// Also flags an all-zero slice result.
module digit_subtractor
    import digit_serial_subtractor_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout,
    output logic             dz
);

    always_comb begin
        logic br;
        br = bin;
        d  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        bout = br;
    end

    assign dz = ~|d;

endmodule

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle a - b - borrow_in, one DIGIT-bit slice per clock, LSB first,
// with valid/ready handshakes on both sides.
module digit_serial_subtractor
    import digit_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int N  = num_slices(WIDTH, DIGIT);
    localparam int CW = cnt_bits(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (!width_ok(WIDTH, DIGIT)) begin : g_bad_geometry
        $error("WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             bor;
    logic             zacc;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] sd;
    logic             sbout;
    logic             sdz;
    logic [WIDTH-1:0] d_next;

    digit_subtractor #(
        .DIGIT (DIGIT)
    ) u_slice (
        .x    (a_sh[DIGIT-1:0]),
        .y    (b_sh[DIGIT-1:0]),
        .bin  (bor),
        .d    (sd),
        .bout (sbout),
        .dz   (sdz)
    );

    // New slice enters at the MSB end; after N shifts slice 0 sits at the LSB.
    assign d_next = (d_sh >> DIGIT) | (WIDTH'(sd) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            d_sh       <= '0;
            bor        <= 1'b0;
            zacc       <= 1'b0;
            cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        d_sh     <= '0;
                        bor      <= borrow_in;
                        zacc     <= 1'b1;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> DIGIT;
                    b_sh <= b_sh >> DIGIT;
                    d_sh <= d_next;
                    bor  <= sbout;
                    zacc <= zacc & sdz;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff       <= d_next;
                        borrow_out <= sbout;
                        zero       <= zacc & sdz;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Directed and randomized bench for digit_serial_subtractor
// against an arithmetic reference model.
module tb_digit_serial_subtractor;

    localparam int NOPS = 1500;
    localparam int WS [4] = '{16, 16, 16, 32};
    localparam int DS [4] = '{1, 4, 16, 8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {borrow, zero, diff} of (a - b - bin) mod 2^w
    function automatic logic [65:0] ref_sub(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic bin);
        logic [64:0] lhs;
        logic [64:0] rhs;
        logic [63:0] mask;
        logic [63:0] d;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        lhs  = {1'b0, a & mask};
        rhs  = {1'b0, b & mask} + 65'(bin);
        d    = 64'(lhs - rhs) & mask;
        return {lhs < rhs, d == 64'd0, d};
    endfunction

    logic        d_rst_n;
    logic        d_in_valid;
    logic        d_in_ready;
    logic [15:0] d_a;
    logic [15:0] d_b;
    logic        d_bin;
    logic        d_out_valid;
    logic        d_out_ready;
    logic [15:0] d_diff;
    logic        d_bout;
    logic        d_zero;

    digit_serial_subtractor #(
        .WIDTH (16),
        .DIGIT (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (d_rst_n),
        .in_valid   (d_in_valid),
        .in_ready   (d_in_ready),
        .a          (d_a),
        .b          (d_b),
        .borrow_in  (d_bin),
        .out_valid  (d_out_valid),
        .out_ready  (d_out_ready),
        .diff       (d_diff),
        .borrow_out (d_bout),
        .zero       (d_zero)
    );

    logic r_rst_n;

    for (genvar g = 0; g < 4; g++) begin : g_rnd
        localparam int W = WS[g];
        localparam int D = DS[g];

        logic         iv;
        logic         ir;
        logic         ov;
        logic         ordy;
        logic         bi;
        logic         bo;
        logic         z;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] df;

        digit_serial_subtractor #(
            .WIDTH (W),
            .DIGIT (D)
        ) u_dut (
            .clk        (clk),
            .rst_n      (r_rst_n),
            .in_valid   (iv),
            .in_ready   (ir),
            .a          (ra),
            .b          (rb),
            .borrow_in  (bi),
            .out_valid  (ov),
            .out_ready  (ordy),
            .diff       (df),
            .borrow_out (bo),
            .zero       (z)
        );

        initial begin
            logic [65:0] e;
            logic [63:0] aw;
            logic [63:0] bw;
            int          n;
            bit          got;
            string       tg;
            tg   = $sformatf("r%0d", g);
            iv   = 1'b0;
            ordy = 1'b0;
            ra   = '0;
            rb   = '0;
            bi   = 1'b0;
            wait (r_rst_n);
            for (int k = 0; k < NOPS; k++) begin
                @(negedge clk);
                aw = {$urandom, $urandom};
                bw = {$urandom, $urandom};
                case ($urandom_range(0, 7))
                    0: bw = aw;
                    1: begin aw = '0; bw = '1; end
                    2: aw = '0;
                    default: ;
                endcase
                ra = W'(aw);
                rb = W'(bw);
                bi = 1'($urandom);
                iv = 1'b1;
                n = 0;
                while (!ir && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (!ir) check({tg, "_accept_timeout"}, 64'(ir), 64'd1);
                e = ref_sub(W, 64'(ra), 64'(rb), bi);
                @(negedge clk);
                iv = ($urandom_range(0, 3) == 0);
                ra = W'($urandom);
                rb = W'($urandom);
                got = 1'b0;
                n = 0;
                while (!got && n < 400) begin
                    ordy = ($urandom_range(0, 3) != 0);
                    if (ov && ordy) begin
                        check({tg, "_diff"}, 64'(df), e[63:0]);
                        check({tg, "_borrow"}, 64'(bo), 64'(e[65]));
                        check({tg, "_zero"}, 64'(z), 64'(e[64]));
                        got = 1'b1;
                    end else begin
                        @(negedge clk);
                        n++;
                    end
                end
                if (!got) check({tg, "_result_timeout"}, 64'(ov), 64'd1);
            end
            @(negedge clk);
            iv = 1'b0;
            done_cnt++;
        end
    end

    task automatic dir_op(input string tag, input logic [15:0] ta,
                          input logic [15:0] tb2, input logic tbin,
                          input logic [15:0] ediff, input logic eb,
                          input logic ez, input int hold, input bit pulse);
        int lat;
        @(negedge clk);
        d_a        = ta;
        d_b        = tb2;
        d_bin      = tbin;
        d_in_valid = 1'b1;
        check({tag, "_in_ready"}, 64'(d_in_ready), 64'd1);
        @(posedge clk);
        #1;
        if (pulse) begin
            d_a   = ~ta;
            d_b   = 16'h0001;
            d_bin = ~tbin;
        end else begin
            d_in_valid = 1'b0;
        end
        lat = 0;
        while (!d_out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_diff"}, 64'(d_diff), 64'(ediff));
        check({tag, "_borrow"}, 64'(d_bout), 64'(eb));
        check({tag, "_zero"}, 64'(d_zero), 64'(ez));
        check({tag, "_busy"}, 64'(d_in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_diff"}, 64'(d_diff), 64'(ediff));
            check({tag, "_hold_flags"}, {62'd0, d_bout, d_zero}, {62'd0, eb, ez});
            check({tag, "_hold_valid"}, 64'(d_out_valid), 64'd1);
            check({tag, "_hold_rdy"}, 64'(d_in_ready), 64'd0);
        end
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        @(posedge clk);
        #1;
        d_out_ready = 1'b0;
        check({tag, "_released"}, {62'd0, d_out_valid, d_in_ready}, 64'd1);
        check({tag, "_idle_diff"}, 64'(d_diff), 64'(ediff));
    endtask

    initial begin
        int n;
        d_rst_n     = 1'b0;
        r_rst_n     = 1'b0;
        d_in_valid  = 1'b0;
        d_out_ready = 1'b0;
        d_a         = '0;
        d_b         = '0;
        d_bin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(d_in_ready), 64'd1);
        check("rst_out_valid", 64'(d_out_valid), 64'd0);
        check("rst_diff", 64'(d_diff), 64'd0);
        check("rst_flags", {62'd0, d_bout, d_zero}, 64'd0);
        @(negedge clk);
        d_rst_n = 1'b1;
        r_rst_n = 1'b1;

        dir_op("t1", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 0, 1'b0);
        dir_op("t2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
        dir_op("t3", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
        dir_op("bp", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 10, 1'b1);

        @(negedge clk);
        d_a        = 16'h00FF;
        d_b        = 16'h0001;
        d_bin      = 1'b0;
        d_in_valid = 1'b1;
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        d_rst_n = 1'b0;
        #1;
        check("mrst_in_ready", 64'(d_in_ready), 64'd1);
        check("mrst_out_valid", 64'(d_out_valid), 64'd0);
        check("mrst_diff", 64'(d_diff), 64'd0);
        check("mrst_flags", {62'd0, d_bout, d_zero}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mrst_no_result", 64'(d_out_valid), 64'd0);
        @(negedge clk);
        d_rst_n = 1'b1;

        dir_op("t4", 16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
        dir_op("t5", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 1'b0);

        n = 0;
        while (done_cnt < 4 && n < 95000) begin
            @(posedge clk);
            n++;
        end
        check("rnd_done", 64'(done_cnt), 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
